rpn_stack_controller: RTL

RPN_STACK_CONTROLLER -- requirements
Module: rpn_stack_controller

---
 rtl/rpn_stack_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rpn_stack_controller.sv
// RPN token sequencer driving an external 4-bit stack over a shared tri-state data bus.
// Operands push directly; ADD/SUB pop two and push the result; DUP reads the top and pushes it again.
module rpn_stack_controller #(
   parameter int unsigned STACK_DEPTH = 5
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       TOK_VALID,
   output logic       TOK_READY,
   input  logic [1:0] TOK_KIND,
   input  logic [3:0] TOK_VAL,
   output logic       RES_VALID,
   output logic [3:0] RES_DATA,
   output logic       ERR,
   output logic [2:0] DEPTH,
   output logic [1:0] STK_COMMAND,
   output logic [2:0] STK_INDEX,
   inout  wire  [3:0] STK_DATA
);

   localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP_A,
      S_POP_B,
      S_GET_T,
      S_PUSH_R,
      S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      KIND_OPND = 2'd0,
      KIND_ADD  = 2'd1,
      KIND_SUB  = 2'd2,
      KIND_DUP  = 2'd3
   } kind_e;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'd0,
      CMD_PUSH = 2'd1,
      CMD_POP  = 2'd2,
      CMD_GET  = 2'd3
   } cmd_e;

   state_e     state_q, state_d;
   kind_e      kind_q, kind_d;
   cmd_e       cmd;
   logic [2:0] depth_q, depth_d;
   logic       err_q, err_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] res_q, res_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         kind_q  <= KIND_OPND;
         depth_q <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         depth_q <= depth_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // The result is computed on the edge entering PUSH_R so RES_DATA and the bus agree for the whole push cycle.
   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      depth_d   = depth_q;
      err_d     = err_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      cmd       = CMD_NOP;
      TOK_READY = 1'b0;
      RES_VALID = 1'b0;

      case (state_q)
         S_IDLE: begin
            TOK_READY = ~err_q;
            if (TOK_VALID && !err_q) begin
               kind_d = kind_e'(TOK_KIND);
               case (kind_e'(TOK_KIND))
                  KIND_OPND: begin
                     if (depth_q < DEPTH_MAX) begin
                        res_d   = TOK_VAL;
                        state_d = S_PUSH_R;
                     end else begin
                        state_d = S_FAULT;
                        err_d   = 1'b1;
                     end
                  end
                  KIND_ADD, KIND_SUB: begin
                     if (depth_q >= 3'd2) begin
                        state_d = S_POP_A;
                     end else begin
                        state_d = S_FAULT;
                        err_d   = 1'b1;
                     end
                  end
                  default: begin
                     if ((depth_q != 3'd0) && (depth_q < DEPTH_MAX)) begin
                        state_d = S_GET_T;
                     end else begin
                        state_d = S_FAULT;
                        err_d   = 1'b1;
                     end
                  end
               endcase
            end
         end
         S_POP_A: begin
            cmd     = CMD_POP;
            a_d     = STK_DATA;
            depth_d = depth_q - 3'd1;
            state_d = S_POP_B;
         end
         S_POP_B: begin
            cmd     = CMD_POP;
            b_d     = STK_DATA;
            depth_d = depth_q - 3'd1;
            res_d   = (kind_q == KIND_SUB) ? (STK_DATA - a_q) : (STK_DATA + a_q);
            state_d = S_PUSH_R;
         end
         S_GET_T: begin
            cmd     = CMD_GET;
            a_d     = STK_DATA;
            res_d   = STK_DATA;
            state_d = S_PUSH_R;
         end
         S_PUSH_R: begin
            cmd       = CMD_PUSH;
            RES_VALID = 1'b1;
            depth_d   = depth_q + 3'd1;
            state_d   = S_IDLE;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign STK_COMMAND = cmd;
   assign STK_INDEX   = '0;
   assign RES_DATA    = res_q;
   assign ERR         = err_q;
   assign DEPTH       = depth_q;
   assign STK_DATA    = (state_q == S_PUSH_R) ? res_q : 4'bzzzz;

endmodule
